// File: rtl/ddr2idx_rd.sv
// ddr2idx_rd: turns an index-pair count and a DDR base address into DDR read
// bursts, then forwards exactly the needed data beats to the index-buffer
// loader through a 2-entry skid FIFO.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   start, base_addr, idx_num   job launch (sampled on start, ignored while busy)
//   done                        one-cycle pulse after the last output handshake
//   rd_addr/rd_len/rd_addr_valid/rd_addr_ready   burst request channel
//   rd_data/rd_data_valid/rd_data_ready          returned data beats
//   out_data/out_valid/out_ready                 beat stream to the loader
module ddr2idx_rd #(
   parameter int DDR_W     = 512,
   parameter int IDX_W     = 16,
   parameter int ADDR_W    = 32,
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              done,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [7:0]        idx_num,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [7:0]        rd_len,
   output logic              rd_addr_valid,
   input  logic              rd_addr_ready,
   input  logic [DDR_W-1:0]  rd_data,
   input  logic              rd_data_valid,
   output logic              rd_data_ready,
   output logic [DDR_W-1:0]  out_data,
   output logic              out_valid,
   input  logic              out_ready
);

   localparam int         IDX_BATCH  = DDR_W / (2 * IDX_W);
   localparam int         BEAT_BYTES = DDR_W / 8;
   localparam logic [8:0] MAXB       = 9'(MAX_BURST);

   typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

   state_t            state;
   logic [ADDR_W-1:0] base;
   logic [8:0]        total, issued, recv, sent;
   logic [1:0]        fcnt;
   logic [DDR_W-1:0]  ent1;   // second FIFO slot; out_data is the head slot

   logic       busy, push, pop;
   logic [8:0] total_new, issued_nxt, sent_nxt;

   function automatic logic [7:0] burst_len(input logic [8:0] left);
      logic [8:0] b;
      b = (left > MAXB) ? MAXB : left;
      return 8'(b - 9'd1);
   endfunction

   assign total_new  = 9'((16'(idx_num) + 16'(IDX_BATCH - 1)) / 16'(IDX_BATCH));
   assign busy       = (state != IDLE);
   assign push       = rd_data_valid && rd_data_ready;
   assign pop        = out_valid && out_ready;
   assign issued_nxt = issued + 9'(rd_len) + 9'd1;
   assign sent_nxt   = sent + 9'(pop);

   // Ready depends only on registered state, never on out_ready.
   assign rd_data_ready = busy && (recv < total) && (fcnt != 2'd2);
   assign out_valid     = (fcnt != 2'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         base          <= '0;
         total         <= '0;
         issued        <= '0;
         recv          <= '0;
         sent          <= '0;
         done          <= 1'b0;
         rd_addr       <= '0;
         rd_len        <= '0;
         rd_addr_valid <= 1'b0;
         fcnt          <= '0;
         ent1          <= '0;
         out_data      <= '0;
      end else begin
         done <= 1'b0;
         if (push) recv <= recv + 9'd1;
         if (pop)  sent <= sent_nxt;

         case (state)
            IDLE: if (start) begin
               issued <= '0;
               recv   <= '0;
               sent   <= '0;
               if (total_new == 9'd0) begin
                  done <= 1'b1;
               end else begin
                  base          <= base_addr;
                  total         <= total_new;
                  rd_addr       <= base_addr;
                  rd_len        <= burst_len(total_new);
                  rd_addr_valid <= 1'b1;
                  state         <= REQ;
               end
            end
            REQ: if (rd_addr_valid && rd_addr_ready) begin
               issued <= issued_nxt;
               if (issued_nxt == total) begin
                  rd_addr_valid <= 1'b0;
                  state         <= DRAIN;
               end else begin
                  rd_addr <= base + ADDR_W'(issued_nxt) * ADDR_W'(BEAT_BYTES);
                  rd_len  <= burst_len(total - issued_nxt);
               end
            end
            DRAIN: if (sent_nxt == total) begin
               // Look at the post-pop count so done lands one cycle after the last pop.
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         // Skid FIFO: head lives directly in out_data so the output is registered.
         case ({push, pop})
            2'b10: begin
               if (fcnt == 2'd0) out_data <= rd_data;
               else              ent1     <= rd_data;
               fcnt <= fcnt + 2'd1;
            end
            2'b01: begin
               out_data <= ent1;
               fcnt     <= fcnt - 2'd1;
            end
            2'b11: begin
               if (fcnt == 2'd1) begin
                  out_data <= rd_data;
               end else begin
                  out_data <= ent1;
                  ent1     <= rd_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ddr2idx_rd.sv
// Directed bench for ddr2idx_rd. A small DDR responder returns each beat as its
// own byte address replicated across the bus, so output order, loss and
// duplication are all visible in the data.
module tb_ddr2idx_rd;

   logic         clk = 1'b0;
   logic         rst, start, done;
   logic [31:0]  base_addr, rd_addr;
   logic [7:0]   idx_num, rd_len;
   logic         rd_addr_valid, rd_addr_ready;
   logic [511:0] rd_data, out_data;
   logic         rd_data_valid, rd_data_ready, out_valid, out_ready;

   always #5 clk = ~clk;

   ddr2idx_rd dut (
      .clk(clk), .rst(rst), .start(start), .done(done),
      .base_addr(base_addr), .idx_num(idx_num),
      .rd_addr(rd_addr), .rd_len(rd_len),
      .rd_addr_valid(rd_addr_valid), .rd_addr_ready(rd_addr_ready),
      .rd_data(rd_data), .rd_data_valid(rd_data_valid), .rd_data_ready(rd_data_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
   );

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // responder / monitor state
   logic [31:0]  pend_q[$];
   logic [31:0]  burst_a[$];
   logic [7:0]   burst_l[$];
   logic [511:0] out_log[$];
   int  done_cnt, done_cyc, last_out_cyc, av_cnt, model_cnt, full_seen, start_cyc, ph;
   bit  ddr_rdy_en, stall_mode;
   bit  pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   function automatic logic [511:0] beat(input logic [31:0] a);
      return {16{a}};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chkd(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change on the falling edge; handshakes are judged 1ns later,
   // which is what the DUT will see on the next rising edge.
   always @(negedge clk) begin
      rd_addr_ready = ddr_rdy_en;
      rd_data_valid = (pend_q.size() > 0);
      rd_data       = (pend_q.size() > 0) ? beat(pend_q[0]) : '0;
      out_ready     = stall_mode ? pat[ph % 4] : 1'b1;
      ph++;
      #1;
      if (rst) begin
         pend_q.delete();
         model_cnt = 0;
      end else begin
         if (model_cnt == 2) begin
            full_seen++;
            chk("fifo_full_ready", rd_data_ready, 0);
         end
         if (rd_addr_valid) av_cnt++;
         if (rd_addr_valid && rd_addr_ready) begin
            burst_a.push_back(rd_addr);
            burst_l.push_back(rd_len);
            for (int b = 0; b <= int'(rd_len); b++) pend_q.push_back(rd_addr + 32'(b * 64));
         end
         if (rd_data_valid && rd_data_ready) begin
            void'(pend_q.pop_front());
            model_cnt++;
         end
         if (out_valid && out_ready) begin
            out_log.push_back(out_data);
            model_cnt--;
            last_out_cyc = cyc;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   task automatic clr();
      burst_a.delete(); burst_l.delete(); out_log.delete();
      done_cnt = 0; done_cyc = -1; last_out_cyc = -1; av_cnt = 0; full_seen = 0;
   endtask

   task automatic launch(input logic [31:0] a, input logic [7:0] n);
      @(negedge clk);
      base_addr = a; idx_num = n; start = 1'b1; start_cyc = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (done_cnt < 1 && n < 500) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      chk(tag, done_cnt, 1);
   endtask

   task automatic check_job(input string tag, input logic [31:0] a, input int beats);
      chk({tag, "_nbeats"}, out_log.size(), beats);
      for (int i = 0; i < beats && i < out_log.size(); i++)
         chkd($sformatf("%s_beat%0d", tag, i), out_log[i], beat(a + 32'(i * 64)));
      chk({tag, "_done_lat"}, done_cyc, last_out_cyc + 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_av"}, rd_addr_valid, 0);
      chk({tag, "_addr"}, rd_addr, 0);
      chk({tag, "_len"}, rd_len, 0);
      chk({tag, "_drdy"}, rd_data_ready, 0);
      chk({tag, "_ov"}, out_valid, 0);
      chkd({tag, "_odata"}, out_data, '0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; base_addr = '0; idx_num = '0;
      ddr_rdy_en = 1'b1; stall_mode = 1'b0; ph = 0;
      clr();
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      rst = 1'b0;

      // basic: 40 pairs -> 3 beats in one burst
      clr();
      launch(32'h1000, 8'd40);
      chk("basic_av_cycle1", rd_addr_valid, 1);
      chk("basic_addr", rd_addr, 32'h1000);
      chk("basic_len", rd_len, 2);
      wait_done("basic_done");
      chk("basic_nbursts", burst_a.size(), 1);
      check_job("basic", 32'h1000, 3);

      // multi-burst: 255 pairs -> 16 beats in four bursts of 4
      clr();
      launch(32'h0, 8'd255);
      wait_done("multi_done");
      chk("multi_nbursts", burst_a.size(), 4);
      for (int i = 0; i < 4 && i < burst_a.size(); i++) begin
         chk($sformatf("multi_addr%0d", i), burst_a[i], 32'(i * 256));
         chk($sformatf("multi_len%0d", i), burst_l[i], 3);
      end
      check_job("multi", 32'h0, 16);

      // downstream stall with out_ready pattern 1-0-0-1
      clr();
      stall_mode = 1'b1;
      launch(32'h0, 8'd255);
      wait_done("stall_done");
      check_job("stall", 32'h0, 16);
      chk("stall_full_seen", full_seen > 0, 1);
      stall_mode = 1'b0;

      // zero length
      clr();
      launch(32'h5000, 8'd0);
      repeat (5) @(negedge clk);
      chk("zero_done_cnt", done_cnt, 1);
      chk("zero_done_cyc", done_cyc, start_cyc + 1);
      chk("zero_no_av", av_cnt, 0);

      // ignored restart: second start while REQ holds
      clr();
      ddr_rdy_en = 1'b0;
      launch(32'h2000, 8'd100);
      @(negedge clk);
      base_addr = 32'h9000; idx_num = 8'd10; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("restart_hold_av", rd_addr_valid, 1);
      chk("restart_hold_addr", rd_addr, 32'h2000);
      chk("restart_hold_len", rd_len, 3);
      ddr_rdy_en = 1'b1;
      wait_done("restart_done");
      repeat (10) @(negedge clk);
      chk("restart_single_done", done_cnt, 1);
      chk("restart_nbursts", burst_a.size(), 2);
      if (burst_a.size() == 2) begin
         chk("restart_addr1", burst_a[1], 32'h2100);
         chk("restart_len1", burst_l[1], 2);
      end
      check_job("restart", 32'h2000, 7);

      // reset mid-job, then a fresh 17-pair job
      clr();
      launch(32'h0, 8'd255);
      begin
         int n = 0;
         while (out_log.size() < 5 && n < 200) begin
            @(negedge clk);
            n++;
         end
      end
      chk("midrst_reached5", out_log.size() >= 5, 1);
      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs("midrst");
      rst = 1'b0;
      clr();
      launch(32'h4000, 8'd17);
      wait_done("fresh_done");
      chk("fresh_nbursts", burst_a.size(), 1);
      if (burst_l.size() > 0) chk("fresh_len", burst_l[0], 1);
      check_job("fresh", 32'h4000, 2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
